probe_conditioner: RTL

Input-conditioning stage between the board probe pins (VC707 GPIO switches) and the correlator's `i_probe` input. It synchronises each asynchronous probe into `clk_48MHz` through an `N_SYNC`-flop chain, then deglitches it with a per-probe stability counter. It also reports per-probe toggle pulses and sticky activity flags for debug and LED use. It is clocked by the PLL-derived 48MHz clock and reset by the fpgaReset output.

---
 rtl/probe_conditioner_pkg.sv | 9 +
 rtl/probe_filter.sv | 57 +++++
 rtl/probe_conditioner.sv | 33 +++
 3 files changed

// File: rtl/probe_conditioner_pkg.sv
// Shared helpers for the probe conditioning slice.
package probe_conditioner_pkg;

  // Filter counter width: $clog2 of the length, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/probe_filter.sv
// One probe bit: synchroniser chain, stability filter, toggle pulse and sticky activity flag.
module probe_filter
  import probe_conditioner_pkg::*;
#(
  parameter int unsigned N_SYNC        = 2,
  parameter int unsigned FILTER_LENGTH = 4
) (
  input  logic clk_48MHz,
  input  logic rst,
  input  logic i_cg,
  input  logic i_pin,
  input  logic i_activityClear,
  output logic o_probe,
  output logic o_toggle,
  output logic o_activity
);

  localparam int unsigned CW = cnt_width(FILTER_LENGTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LENGTH - 1);

  logic [N_SYNC-1:0] sync;
  logic [CW-1:0]     cnt;
  logic              s;

  assign s = sync[N_SYNC-1];

  always_ff @(posedge clk_48MHz) begin
    if (rst) begin
      sync       <= '0;
      cnt        <= '0;
      o_probe    <= 1'b0;
      o_toggle   <= 1'b0;
      o_activity <= 1'b0;
    end else begin
      // The synchroniser ignores i_cg so metastability settling time is never lost.
      sync     <= {sync[N_SYNC-2:0], i_pin};
      o_toggle <= 1'b0;
      if (i_cg) begin
        if (s == o_probe) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          o_probe  <= s;
          cnt      <= '0;
          o_toggle <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // A toggle wins over a coincident clear so no event is lost.
      if (o_toggle)
        o_activity <= 1'b1;
      else if (i_activityClear)
        o_activity <= 1'b0;
    end
  end

endmodule

// File: rtl/probe_conditioner.sv
// Vector wrapper: one independent probe_filter per probe pin, shared gate and clear.
module probe_conditioner #(
  parameter int unsigned N_PROBE       = 4,
  parameter int unsigned N_SYNC        = 2,
  parameter int unsigned FILTER_LENGTH = 4
) (
  input  logic               clk_48MHz,
  input  logic               rst,
  input  logic               i_cg,
  input  logic [N_PROBE-1:0] i_pin_probe,
  input  logic               i_activityClear,
  output logic [N_PROBE-1:0] o_probe,
  output logic [N_PROBE-1:0] o_toggle,
  output logic [N_PROBE-1:0] o_activity
);

  for (genvar i = 0; i < N_PROBE; i++) begin : g_probe
    probe_filter #(
      .N_SYNC        (N_SYNC),
      .FILTER_LENGTH (FILTER_LENGTH)
    ) u_filter (
      .clk_48MHz       (clk_48MHz),
      .rst             (rst),
      .i_cg            (i_cg),
      .i_pin           (i_pin_probe[i]),
      .i_activityClear (i_activityClear),
      .o_probe         (o_probe[i]),
      .o_toggle        (o_toggle[i]),
      .o_activity      (o_activity[i])
    );
  end

endmodule
